// File: rtl/apb_slv_regbank.sv
// APB4 slave register bank: DEPTH word registers with byte strobes, programmable
// wait states, PSLVERR on misaligned/out-of-range/read-only-write access.
module apb_slv_regbank #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int RO_BASE     = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic                                  PCLK,
    input  logic                                  PRESETn,
    input  logic                                  PSELx,
    input  logic                                  PENABLE,
    input  logic                                  PWRITE,
    input  logic [ADDR_WIDTH-1:0]                 PADDR,
    input  logic [DATA_WIDTH-1:0]                 PWDATA,
    input  logic [DATA_WIDTH/8-1:0]               PSTRB,
    input  logic [(DEPTH-RO_BASE)*DATA_WIDTH-1:0] hw_status,
    output logic [DATA_WIDTH-1:0]                 PRDATA,
    output logic                                  PREADY,
    output logic                                  PSLVERR
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int NRO = DEPTH - RO_BASE;
    localparam int NRW = (RO_BASE > 0) ? RO_BASE : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic [ADDR_WIDTH-1:0]   lat_idx;
    logic                    lat_wr;
    logic                    lat_err;
    logic [DATA_WIDTH-1:0]   regs [NRW];

    logic [ADDR_WIDTH-1:0]   idx;
    logic                    err;
    logic                    setup;
    logic                    done;
    logic                    wr_fire;
    logic [DATA_WIDTH-1:0]   rd_val;

    // Address decode is evaluated only at the setup edge and latched for the access phase.
    assign idx = PADDR >> LSB;
    assign err = ((PADDR & ADDR_WIDTH'(NB - 1)) != '0)
              || ({1'b0, idx} >= (ADDR_WIDTH + 1)'(DEPTH))
              || (PWRITE && ({1'b0, idx} >= (ADDR_WIDTH + 1)'(RO_BASE)));

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < RO_BASE; i++)
            if (idx == ADDR_WIDTH'(i)) rd_val = regs[i];
        for (int i = 0; i < NRO; i++)
            if (idx == ADDR_WIDTH'(RO_BASE + i)) rd_val = hw_status[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // PREADY decodes registered state only, so there is no combinational path from the bus.
    assign PREADY  = (state == ACCESS) && (cnt == 4'd0);
    assign PSLVERR = PREADY && lat_err;
    assign setup   = (state == IDLE) && PSELx && !PENABLE;
    assign done    = PREADY && PSELx && PENABLE;
    assign wr_fire = done && lat_wr && !lat_err;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            cnt     <= '0;
            lat_idx <= '0;
            lat_wr  <= 1'b0;
            lat_err <= 1'b0;
            PRDATA  <= '0;
        end else if (state == IDLE) begin
            if (setup) begin
                state   <= ACCESS;
                cnt     <= 4'(WAIT_STATES);
                lat_idx <= idx;
                lat_wr  <= PWRITE;
                lat_err <= err;
                PRDATA  <= (!PWRITE && !err) ? rd_val : '0;
            end
        end else begin
            // Deselect mid-access abandons the transfer; completion returns to IDLE.
            if (!PSELx || done) begin
                state  <= IDLE;
                cnt    <= '0;
                PRDATA <= '0;
            end else if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NRW; i++) regs[i] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < RO_BASE; i++)
                if (lat_idx == ADDR_WIDTH'(i))
                    for (int b = 0; b < NB; b++)
                        if (PSTRB[b]) regs[i][8*b +: 8] <= PWDATA[8*b +: 8];
        end
    end

endmodule
